risc_mem_responder: RTL and testbench
=====================================

Name: risc_mem_responder

Overview:
- Unified 1024x32 memory responder for the RISC pipeline, on the memory side of both of its memory paths.
- Serves the instruction-fetch port (read-only) and the data port (LW read / SW write).
- Uses a req/gnt/rvalid handshake, fixed arbitration with a starvation guard, and programmable wait states, so the core can run against a slower, shared memory model.

Parameters:
- ADDR_W, 10, word-address width; depth = 2**ADDR_W words.
- DATA_W, 32, word width.
- WAIT_STATES, 1, extra busy cycles per access (0..15).
- STARVE_LIMIT, 4, consecutive fetch losses before fetch is forced to win.
- TEXT_TOP, 64, first writable word address (used only with the optional feature).

Ports:
- clk1  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  fetch request accepted this cycle (combinational).
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction word.
- d_req  in  1  data request; held with d_we, d_addr, d_wdata stable until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted this cycle (combinational).
- d_rvalid  out  1  one-cycle pulse; load data valid, or store acknowledged.
- d_rdata  out  DATA_W  load data.
- d_err  out  1  one-cycle pulse with d_rvalid when a store was rejected (optional feature only; tied 0 otherwise).
- busy  out  1  a transaction is in flight.

Behaviour:
- Clock and reset: single clock clk1. Reset rst is asynchronous, active-high.
- Reset values: all outputs 0, state IDLE, wait counter 0, starvation counter 0. Memory array is not reset; contents are retained.
- FSM has two states, IDLE and BUSY. At most one transaction is outstanding across both ports.
- IDLE: a grant is issued only in IDLE.
  - Only d_req: d_gnt=1.
  - Only if_req: if_gnt=1.
  - Both: d_gnt=1 (MEM stage is older), unless the starvation counter equals STARVE_LIMIT, in which case if_gnt=1.
  - if_gnt and d_gnt are never both 1.
- On the grant edge:
  - Latch port id, we, addr, wdata.
  - Load wait counter with WAIT_STATES.
  - Go to BUSY.
- BUSY:
  - Counter != 0: decrement.
  - Counter == 0: at that edge, perform the access:
    - Read: mem[addr] goes to the selected port's rdata register.
    - Write: mem[addr] <= wdata.
  - Then pulse that port's rvalid for the next cycle and return to IDLE.
- Latency: gnt in cycle T gives rvalid in cycle T+2+WAIT_STATES. A new gnt may be asserted in the same cycle as rvalid, so throughput is 1 transaction per WAIT_STATES+2 cycles.
- rdata holds its value until the next read response on that port. d_rdata is unchanged by a store.
- Starvation counter:
  - Increments when if_req and d_req are both high and d_gnt wins.
  - Clears on any if_gnt.
  - Saturates at STARVE_LIMIT.
- Request dropped before its grant: nothing happens and no error is raised.
- Address width equals the array depth, so no out-of-range case exists; addresses do not wrap beyond ADDR_W.
- Reset mid-transaction: the transaction is abandoned, no write is committed, no rvalid is issued, and the FSM goes to IDLE.
- busy = (state == BUSY).

Optional Feature:
- Macro: RISC_MEM_WRITE_PROTECT_EN.
- Defined: a store with d_addr < TEXT_TOP is not written to memory; d_rvalid and d_err pulse together at normal latency. Loads and fetches are unaffected.
- Undefined: all stores are written and d_err is constant 0.

Test Plan:
- Store/load: store 32'h00000055 to addr 120, then load addr 120 -> d_rvalid with d_rdata=32'h00000055; with WAIT_STATES=1, rvalid occurs 3 cycles after d_gnt.
- Fetch: store 32'h2801000A to addr 70 and 32'hFC000000 to addr 71, then fetch 70 and 71 -> if_rdata=32'h2801000A, then 32'hFC000000, each on its own if_rvalid pulse.
- Contention: hold if_req and d_req high continuously with STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,D,D,D,I; never both gnts in one cycle.
- Reset mid-store: assert rst during BUSY of a store of 32'hDEADBEEF to addr 200 (old value 7) -> no d_rvalid; a load of addr 200 after reset returns 7; all outputs 0 during reset.
- WAIT_STATES=0: back-to-back loads of addr 120 and 121 -> rvalid at gnt+2, second gnt in the same cycle as the first rvalid.
- RISC_MEM_WRITE_PROTECT_EN defined: store 32'h12345678 to addr 5 -> d_rvalid=1 with d_err=1; a load of addr 5 returns its prior value. The same store without the macro -> value written, d_err=0.

Source files
------------

// File: rtl/risc_mem_responder.sv
// risc_mem_responder: unified 1024x32 memory responder serving the fetch port and the data port
// Ports: clk1/rst (async, active-high); fetch if_req/if_addr -> if_gnt/if_rvalid/if_rdata;
//   data d_req/d_we/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata/d_err; busy flags a transaction in flight.
// Optional: define RISC_MEM_WRITE_PROTECT_EN to reject stores below TEXT_TOP, signalled by d_err.
module risc_mem_responder #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int WAIT_STATES  = 1,
  parameter int STARVE_LIMIT = 4,
  parameter int TEXT_TOP     = 64
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              busy
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
`ifdef RISC_MEM_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  state_t            r_state;
  logic              r_dport, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_cnt;
  logic [SW-1:0]     r_starve;
  logic              w_idle, w_done, w_prot;
  assign w_idle = r_state == IDLE;
  assign w_done = r_state == BUSY && r_cnt == '0;
  assign w_prot = WP && r_we && r_addr < ADDR_W'(TEXT_TOP);
  // data wins ties unless fetch has lost STARVE_LIMIT times in a row
  assign d_gnt  = w_idle && d_req && !(if_req && r_starve == SW'(STARVE_LIMIT));
  assign if_gnt = w_idle && if_req && !d_gnt;
  assign busy   = r_state == BUSY;
  // the array is not reset; a reset during the access edge must not commit the store
  always_ff @(posedge clk1)
    if (w_done && r_we && !w_prot && !rst) r_mem[r_addr] <= r_wdata;
  always_ff @(posedge clk1 or posedge rst)
    if (rst) begin
      r_state   <= IDLE;
      r_dport   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_starve  <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
      // d_gnt with if_req pending only happens below the limit, so this saturates by construction
      if (if_gnt) r_starve <= '0;
      else if (d_gnt && if_req) r_starve <= r_starve + 1'b1;
      if (if_gnt || d_gnt) begin
        r_state <= BUSY;
        r_dport <= d_gnt;
        r_we    <= d_gnt && d_we;
        r_addr  <= d_gnt ? d_addr : if_addr;
        r_wdata <= d_wdata;
        r_cnt   <= 4'(WAIT_STATES);
      end else if (r_state == BUSY) begin
        if (!w_done) r_cnt <= r_cnt - 1'b1;
        else begin
          r_state <= IDLE;
          if (r_dport) begin
            d_rvalid <= 1'b1;
            d_err    <= w_prot;
            if (!r_we) d_rdata <= r_mem[r_addr];
          end else begin
            if_rvalid <= 1'b1;
            if_rdata  <= r_mem[r_addr];
          end
        end
      end
    end
endmodule

// File: tb/tb_risc_mem_responder.sv
// tb_risc_mem_responder: directed self-checking bench for risc_mem_responder
module tb_risc_mem_responder;
  logic clk1 = 1'b0, rst = 1'b1;
  logic if_req = 0, if_gnt, if_rvalid, d_req = 0, d_we = 0, d_gnt, d_rvalid, d_err, busy;
  logic [9:0] if_addr = '0, d_addr = '0;
  logic [31:0] if_rdata, d_wdata = '0, d_rdata;
  logic if_req0 = 0, if_gnt0, if_rvalid0, d_req0 = 0, d_we0 = 0, d_gnt0, d_rvalid0, d_err0, busy0;
  logic [9:0] if_addr0 = '0, d_addr0 = '0;
  logic [31:0] if_rdata0, d_wdata0 = '0, d_rdata0;
  int checks = 0, failures = 0, cyc = 0;
  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc <= cyc + 1;
  risc_mem_responder u_dut (
    .clk1(clk1), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err), .busy(busy));
  risc_mem_responder #(.WAIT_STATES(0)) u_dut0 (
    .clk1(clk1), .rst(rst), .if_req(if_req0), .if_addr(if_addr0), .if_gnt(if_gnt0),
    .if_rvalid(if_rvalid0), .if_rdata(if_rdata0), .d_req(d_req0), .d_we(d_we0), .d_addr(d_addr0),
    .d_wdata(d_wdata0), .d_gnt(d_gnt0), .d_rvalid(d_rvalid0), .d_rdata(d_rdata0), .d_err(d_err0), .busy(busy0));
  task automatic d_txn(input bit sel, input logic we, input logic [9:0] a, input logic [31:0] wd, output int lat);
    int n = 0;
    bit ok;
    @(posedge clk1); #1;
    if (sel) begin d_req0 = 1; d_we0 = we; d_addr0 = a; d_wdata0 = wd; end
    else begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; end
    @(negedge clk1);
    while (!(sel ? d_gnt0 : d_gnt) && n < 20) begin @(negedge clk1); n++; end
    ok = sel ? d_gnt0 : d_gnt;
    @(posedge clk1); #1;
    d_req = 0; d_req0 = 0;
    lat = 0;
    if (!ok) begin lat = 99; return; end
    do begin @(negedge clk1); lat++; end while (!(sel ? d_rvalid0 : d_rvalid) && lat < 20);
  endtask
  task automatic i_txn(input logic [9:0] a, output int lat);
    int n = 0;
    bit ok;
    @(posedge clk1); #1;
    if_req = 1; if_addr = a;
    @(negedge clk1);
    while (!if_gnt && n < 20) begin @(negedge clk1); n++; end
    ok = if_gnt;
    @(posedge clk1); #1;
    if_req = 0;
    lat = 0;
    if (!ok) begin lat = 99; return; end
    do begin @(negedge clk1); lat++; end while (!if_rvalid && lat < 20);
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    checks++;
    if ({if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err, busy} !== '0) begin
      failures++; $display("FAIL reset_outputs got busy=%b d_rvalid=%b if_rvalid=%b exp all 0", busy, d_rvalid, if_rvalid);
    end
    checks++;
    if ({if_gnt0, if_rvalid0, if_rdata0, d_gnt0, d_rvalid0, d_rdata0, d_err0, busy0} !== '0) begin
      failures++; $display("FAIL reset_outputs_ws0 got busy=%b exp all 0", busy0);
    end
    @(posedge clk1); #1 rst = 0;
  endtask
  task automatic test_store_load;
    int lat;
    d_txn(0, 1, 120, 32'h00000055, lat);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL store_latency got=%0d exp=3", lat); end
    checks++;
    if (d_err !== 1'b0) begin failures++; $display("FAIL store_err got=%b exp=0", d_err); end
    d_txn(0, 0, 120, 0, lat);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL load_latency got=%0d exp=3", lat); end
    checks++;
    if (d_rdata !== 32'h00000055) begin failures++; $display("FAIL load_data got=%h exp=00000055", d_rdata); end
    d_txn(0, 1, 121, 32'h00000099, lat);
    checks++;
    if (d_rdata !== 32'h00000055) begin failures++; $display("FAIL rdata_hold_on_store got=%h exp=00000055", d_rdata); end
  endtask
  task automatic test_fetch;
    int lat;
    d_txn(0, 1, 70, 32'h2801000A, lat);
    d_txn(0, 1, 71, 32'hFC000000, lat);
    i_txn(70, lat);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL fetch_latency got=%0d exp=3", lat); end
    checks++;
    if (if_rdata !== 32'h2801000A) begin failures++; $display("FAIL fetch70 got=%h exp=2801000a", if_rdata); end
    i_txn(71, lat);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hFC000000) begin
      failures++; $display("FAIL fetch71 got=%h rvalid=%b exp=fc000000", if_rdata, if_rvalid);
    end
  endtask
  task automatic test_contention;
    logic [9:0] seq = '0;
    int k = 0;
    bit both = 0;
    rst = 1;
    @(posedge clk1); #1 rst = 0;
    if_req = 1; if_addr = 70; d_req = 1; d_we = 0; d_addr = 120;
    for (int i = 0; i < 200 && k < 10; i++) begin
      @(negedge clk1);
      if (if_gnt && d_gnt) both = 1;
      if (if_gnt || d_gnt) begin seq[k] = if_gnt; k++; end
      @(posedge clk1); #1;
    end
    if_req = 0; d_req = 0;
    checks++;
    if (k !== 10) begin failures++; $display("FAIL contention_grants got=%0d exp=10", k); end
    checks++;
    if (seq !== 10'b1000010000) begin failures++; $display("FAIL contention_order got=%b exp=1000010000 (bit0 first, 1=fetch)", seq); end
    checks++;
    if (both !== 1'b0) begin failures++; $display("FAIL contention_dual_gnt got=%b exp=0", both); end
    repeat (5) @(posedge clk1);
  endtask
  task automatic test_reset_mid;
    int lat;
    bit seen = 0;
    d_txn(0, 1, 200, 32'd7, lat);
    @(posedge clk1); #1;
    d_req = 1; d_we = 1; d_addr = 200; d_wdata = 32'hDEADBEEF;
    @(negedge clk1);
    checks++;
    if (d_gnt !== 1'b1) begin failures++; $display("FAIL mid_store_gnt got=%b exp=1", d_gnt); end
    @(posedge clk1); #1;
    d_req = 0;
    #2 rst = 1;
    #1;
    checks++;
    if ({if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err, busy} !== '0) begin
      failures++; $display("FAIL mid_reset_outputs got busy=%b d_rdata=%h exp all 0", busy, d_rdata);
    end
    repeat (2) @(posedge clk1);
    #1 rst = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk1); if (d_rvalid) seen = 1; end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL mid_reset_rvalid got=%b exp=0", seen); end
    d_txn(0, 0, 200, 0, lat);
    checks++;
    if (d_rdata !== 32'd7) begin failures++; $display("FAIL mid_reset_no_commit got=%h exp=00000007", d_rdata); end
  endtask
  task automatic test_back_to_back;
    int lat, g1 = -1, g2 = -1, r1 = -1, r2 = -1;
    logic [31:0] v1 = '0, v2 = '0;
    d_txn(1, 1, 120, 32'h000000A1, lat);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL ws0_latency got=%0d exp=2", lat); end
    d_txn(1, 1, 121, 32'h000000B2, lat);
    @(posedge clk1); #1;
    d_req0 = 1; d_we0 = 0; d_addr0 = 120;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk1);
      if (d_rvalid0) begin
        if (r1 < 0) begin r1 = cyc; v1 = d_rdata0; end
        else if (r2 < 0) begin r2 = cyc; v2 = d_rdata0; end
      end
      if (d_gnt0) begin
        if (g1 < 0) g1 = cyc;
        else if (g2 < 0) g2 = cyc;
      end
      @(posedge clk1); #1;
      if (g2 >= 0) d_req0 = 0;
      else if (g1 >= 0) d_addr0 = 121;
    end
    checks++;
    if (g1 < 0 || r1 !== g1 + 2) begin failures++; $display("FAIL b2b_first_rvalid got=%0d exp=%0d", r1, g1 + 2); end
    checks++;
    if (g2 !== r1) begin failures++; $display("FAIL b2b_second_gnt got=%0d exp=%0d", g2, r1); end
    checks++;
    if (g2 < 0 || r2 !== g2 + 2) begin failures++; $display("FAIL b2b_second_rvalid got=%0d exp=%0d", r2, g2 + 2); end
    checks++;
    if (v1 !== 32'h000000A1 || v2 !== 32'h000000B2) begin
      failures++; $display("FAIL b2b_data got=%h,%h exp=000000a1,000000b2", v1, v2);
    end
  endtask
  task automatic test_write_protect;
    int lat;
    logic [31:0] v0, exp_v;
    logic exp_err;
    d_txn(0, 0, 5, 0, lat);
    v0 = d_rdata;
`ifdef RISC_MEM_WRITE_PROTECT_EN
    exp_err = 1'b1; exp_v = v0;
`else
    exp_err = 1'b0; exp_v = 32'h12345678;
`endif
    d_txn(0, 1, 5, 32'h12345678, lat);
    checks++;
    if (lat !== 3 || d_rvalid !== 1'b1) begin failures++; $display("FAIL wp_store_ack got lat=%0d exp=3", lat); end
    checks++;
    if (d_err !== exp_err) begin failures++; $display("FAIL wp_err got=%b exp=%b", d_err, exp_err); end
    d_txn(0, 0, 5, 0, lat);
    checks++;
    if (d_rdata !== exp_v) begin failures++; $display("FAIL wp_readback got=%h exp=%h", d_rdata, exp_v); end
  endtask
  initial begin
    test_reset;
    test_store_load;
    test_fetch;
    test_contention;
    test_reset_mid;
    test_back_to_back;
    test_write_protect;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
